// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the stall_ctl pipeline front end:
//   state_t  - stall controller FSM encoding (RUN=0, STALL=1, FLUSH=2)
//   NOP      - instruction word injected into IF/ID on a redirect
//   PC_STEP  - fetch PC increment
//   CNT_W / CNT_MAX - width and saturation value of the stall watchdog counter
//   pc_next  - 32-bit modulo PC advance
//   sat_inc  - saturating increment for the stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Plain 32-bit add: 32'hFFFF_FFFC wraps to 32'h0000_0000.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stall_ctl_if.sv
// -----------------------------------------------------------------------------
// stall_ctl_if
// Bundles the hazard-unit inputs, fetch data and pipeline-register outputs
// of stall_ctl. Clock and reset are kept as plain ports on the modules.
//   master : environment side (drives hazard/fetch inputs, observes outputs)
//   slave  : stall_ctl side
// Inputs : pc_wr_in, if_id_wr_in, flush_control_in, branch_taken_in,
//          branch_target_in[31:0], instr_in[31:0], ctrl_in[CTRL_W-1:0]
// Outputs: pc_out[31:0], if_id_pc4_out[31:0], if_id_instr_out[31:0],
//          id_ex_ctrl_out[CTRL_W-1:0], state_out[1:0], stall_timeout_out
// Build option: STALL_STATS_EN adds stall_count_out[31:0], flush_count_out[31:0].
// -----------------------------------------------------------------------------
interface stall_ctl_if #(
    parameter int CTRL_W = 9
);
    logic              pc_wr_in;
    logic              if_id_wr_in;
    logic              flush_control_in;
    logic              branch_taken_in;
    logic [31:0]       branch_target_in;
    logic [31:0]       instr_in;
    logic [CTRL_W-1:0] ctrl_in;

    logic [31:0]       pc_out;
    logic [31:0]       if_id_pc4_out;
    logic [31:0]       if_id_instr_out;
    logic [CTRL_W-1:0] id_ex_ctrl_out;
    logic [1:0]        state_out;
    logic              stall_timeout_out;
`ifdef STALL_STATS_EN
    logic [31:0]       stall_count_out;
    logic [31:0]       flush_count_out;
`endif

    modport master (
        output pc_wr_in, if_id_wr_in, flush_control_in, branch_taken_in,
               branch_target_in, instr_in, ctrl_in,
        input  pc_out, if_id_pc4_out, if_id_instr_out, id_ex_ctrl_out,
               state_out, stall_timeout_out
`ifdef STALL_STATS_EN
        , input stall_count_out, flush_count_out
`endif
    );

    modport slave (
        input  pc_wr_in, if_id_wr_in, flush_control_in, branch_taken_in,
               branch_target_in, instr_in, ctrl_in,
        output pc_out, if_id_pc4_out, if_id_instr_out, id_ex_ctrl_out,
               state_out, stall_timeout_out
`ifdef STALL_STATS_EN
        , output stall_count_out, flush_count_out
`endif
    );

endinterface

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with hold and flush.
//   clock_in   - clock, rising edge
//   reset_n_in - asynchronous active-low reset (clears to PC4=0, NOP)
//   i_flush    - load a bubble (PC4=0, NOP); wins over i_wr_en
//   i_wr_en    - load i_pc4/i_instr; 0 holds the current contents
//   i_pc4      - PC+4 of the instruction being fetched
//   i_instr    - fetched instruction word
//   o_pc4      - registered PC+4
//   o_instr    - registered instruction
// -----------------------------------------------------------------------------
module if_id_reg
    import pipe_pkg::*;
(
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        i_flush,
    input  logic        i_wr_en,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr
);

    logic [31:0] r_pc4;
    logic [31:0] r_instr;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pc4   <= '0;
            r_instr <= NOP;
        end else if (i_flush) begin
            r_pc4   <= '0;
            r_instr <= NOP;
        end else if (i_wr_en) begin
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
        end
    end

    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;

endmodule

// File: rtl/stall_ctl.sv
// -----------------------------------------------------------------------------
// stall_ctl
// Front-end pipeline controller: fetch PC, IF/ID register (if_id_reg),
// ID/EX control register, RUN/STALL/FLUSH state machine and a stall
// watchdog with a sticky timeout flag.
//
// Per-cycle priority: branch redirect, then stall, then normal advance.
//
// Parameters
//   RESET_PC    - PC loaded on reset
//   CTRL_W      - width of the decoded control bundle
//   STALL_LIMIT - consecutive stall cycles that trip the watchdog (1..255)
// Ports
//   clock_in    - clock, all state on rising edge
//   reset_n_in  - asynchronous active-low reset
//   bus         - stall_ctl_if.slave (hazard inputs, fetch data, outputs)
// Build option
//   STALL_STATS_EN - adds 32-bit wrapping totals of stall cycles and
//                    redirects (bus.stall_count_out / bus.flush_count_out)
// -----------------------------------------------------------------------------
module stall_ctl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          CTRL_W      = 9,
    parameter int          STALL_LIMIT = 15
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    stall_ctl_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STALL_LIMIT);

    logic                w_redirect;
    logic                w_stall;
    logic [31:0]         w_pc_plus4;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [31:0]         w_if_id_pc4;
    logic [31:0]         w_if_id_instr;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout;

    assign w_redirect = bus.branch_taken_in;
    // Either write enable low counts as a stall cycle, even if the other
    // register is still allowed to advance.
    assign w_stall    = ~bus.pc_wr_in | ~bus.if_id_wr_in;
    assign w_pc_plus4 = pc_next(r_pc);

    // Consecutive-stall count; a redirect or any non-stall cycle clears it.
    always_comb begin
        w_cnt_nxt = '0;
        if (!w_redirect && w_stall) begin
            w_cnt_nxt = sat_inc(r_cnt);
        end
    end

    // ---- IF/ID register --------------------------------------------------
    if_id_reg u_if_id (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .i_flush    (w_redirect),
        .i_wr_en    (bus.if_id_wr_in),
        .i_pc4      (w_pc_plus4),
        .i_instr    (bus.instr_in),
        .o_pc4      (w_if_id_pc4),
        .o_instr    (w_if_id_instr)
    );

    // ---- FSM, PC, ID/EX control and watchdog ------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_ctrl    <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            // Counter only climbs one step at a time from zero, so equality
            // catches the crossing; the flag is sticky afterwards.
            if (w_cnt_nxt == LIMIT_C) begin
                r_timeout <= 1'b1;
            end

            if (w_redirect) begin
                r_state <= FLUSH;
                r_pc    <= bus.branch_target_in;
                r_ctrl  <= '0;
            end else begin
                r_state <= w_stall ? STALL : RUN;
                if (bus.pc_wr_in) begin
                    r_pc <= w_pc_plus4;
                end
                // Bubble into EX on request; otherwise the decoded control
                // moves on even while fetch is stalled.
                r_ctrl <= bus.flush_control_in ? '0 : bus.ctrl_in;
            end
        end
    end

    assign bus.pc_out            = r_pc;
    assign bus.if_id_pc4_out     = w_if_id_pc4;
    assign bus.if_id_instr_out   = w_if_id_instr;
    assign bus.id_ex_ctrl_out    = r_ctrl;
    assign bus.state_out         = r_state;
    assign bus.stall_timeout_out = r_timeout;

`ifdef STALL_STATS_EN
    logic [31:0] r_stall_total;
    logic [31:0] r_flush_total;

    // ---- statistics counters ----------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_stall_total <= '0;
            r_flush_total <= '0;
        end else if (w_redirect) begin
            r_flush_total <= r_flush_total + 32'd1;
        end else if (w_stall) begin
            r_stall_total <= r_stall_total + 32'd1;
        end
    end

    assign bus.stall_count_out = r_stall_total;
    assign bus.flush_count_out = r_flush_total;
`endif

endmodule

// File: tb/tb_stall_ctl.sv
module tb_stall_ctl;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          CTRL_W      = 9;
    localparam int          STALL_LIMIT = 15;

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       pc4;
        logic [31:0]       instr;
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        st;
        logic              to;
        logic [31:0]       sc;
        logic [31:0]       fc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t q[$];
    exp_t e_mon;

    // Reference model state, updated once per driven cycle.
    logic [31:0]       m_pc;
    logic [31:0]       m_pc4;
    logic [31:0]       m_instr;
    logic [CTRL_W-1:0] m_ctrl;
    logic [1:0]        m_st;
    int                m_run;
    logic              m_to;
    logic [31:0]       m_sc;
    logic [31:0]       m_fc;

    stall_ctl_if #(.CTRL_W(CTRL_W)) bus_if ();

    stall_ctl #(
        .RESET_PC    (RESET_PC),
        .CTRL_W      (CTRL_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_pc4   = 32'h0;
        m_instr = 32'h0;
        m_ctrl  = '0;
        m_st    = 2'd0;
        m_run   = 0;
        m_to    = 1'b0;
        m_sc    = 32'h0;
        m_fc    = 32'h0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pc"},    64'(bus_if.pc_out),            64'(RESET_PC));
        chk({tag, "_pc4"},   64'(bus_if.if_id_pc4_out),     64'h0);
        chk({tag, "_instr"}, 64'(bus_if.if_id_instr_out),   64'h0);
        chk({tag, "_ctrl"},  64'(bus_if.id_ex_ctrl_out),    64'h0);
        chk({tag, "_state"}, 64'(bus_if.state_out),         64'h0);
        chk({tag, "_tmo"},   64'(bus_if.stall_timeout_out), 64'h0);
`ifdef STALL_STATS_EN
        chk({tag, "_scnt"},  64'(bus_if.stall_count_out),   64'h0);
        chk({tag, "_fcnt"},  64'(bus_if.flush_count_out),   64'h0);
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model by the
    // rules (redirect > stall > advance) and queue what the next rising edge
    // must produce.
    task automatic step(input logic pcw, input logic ifw, input logic fl, input logic br,
                        input logic [31:0] tgt, input logic [31:0] ins,
                        input logic [CTRL_W-1:0] ctl);
        exp_t        e;
        logic [31:0] old_pc;
        @(negedge clk);
        bus_if.pc_wr_in         = pcw;
        bus_if.if_id_wr_in      = ifw;
        bus_if.flush_control_in = fl;
        bus_if.branch_taken_in  = br;
        bus_if.branch_target_in = tgt;
        bus_if.instr_in         = ins;
        bus_if.ctrl_in          = ctl;
        old_pc = m_pc;
        if (br) begin
            m_pc    = tgt;
            m_pc4   = 32'h0;
            m_instr = 32'h0;
            m_ctrl  = '0;
            m_st    = 2'd2;
            m_run   = 0;
            m_fc    = m_fc + 32'd1;
        end else begin
            if (pcw) m_pc = old_pc + 32'd4;
            if (ifw) begin
                m_pc4   = old_pc + 32'd4;
                m_instr = ins;
            end
            m_ctrl = fl ? '0 : ctl;
            if (!pcw || !ifw) begin
                m_st  = 2'd1;
                m_run = (m_run < 255) ? m_run + 1 : 255;
                m_sc  = m_sc + 32'd1;
                if (m_run >= STALL_LIMIT) m_to = 1'b1;
            end else begin
                m_st  = 2'd0;
                m_run = 0;
            end
        end
        e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.ctrl = m_ctrl;
        e.st = m_st; e.to = m_to; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
    endtask

    task automatic run_cycle(input logic [31:0] ins, input logic [CTRL_W-1:0] ctl);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, ins, ctl);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every expected entry belongs to the next rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e_mon = q.pop_front();
                chk("pc",       64'(bus_if.pc_out),            64'(e_mon.pc));
                chk("if_pc4",   64'(bus_if.if_id_pc4_out),     64'(e_mon.pc4));
                chk("if_instr", 64'(bus_if.if_id_instr_out),   64'(e_mon.instr));
                chk("ex_ctrl",  64'(bus_if.id_ex_ctrl_out),    64'(e_mon.ctrl));
                chk("state",    64'(bus_if.state_out),         64'(e_mon.st));
                chk("timeout",  64'(bus_if.stall_timeout_out), 64'(e_mon.to));
`ifdef STALL_STATS_EN
                chk("stall_cnt", 64'(bus_if.stall_count_out),  64'(e_mon.sc));
                chk("flush_cnt", 64'(bus_if.flush_count_out),  64'(e_mon.fc));
`endif
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        br;
        int          wait_cnt;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus_if.pc_wr_in         = 1'b1;
        bus_if.if_id_wr_in      = 1'b1;
        bus_if.flush_control_in = 1'b0;
        bus_if.branch_taken_in  = 1'b0;
        bus_if.branch_target_in = 32'h0;
        bus_if.instr_in         = 32'h0;
        bus_if.ctrl_in          = '0;
        model_reset();

        // Power-on reset, released between edges.
        #2 rst_n = 1'b0;
        #1 chk_reset_values("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Normal advance from reset: 4, 8, 12.
        run_cycle(32'h1111_0001, 9'h011);
        run_cycle(32'h1111_0002, 9'h022);
        run_cycle(32'h1111_0003, 9'h033);
        after_edge();
        chk("pc_after_3", 64'(bus_if.pc_out), 64'd12);

        // Load-use bubble: full hold plus control flush, then resume.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h2222_0000, 9'h1FF);
        after_edge();
        chk("loaduse_pc_hold", 64'(bus_if.pc_out), 64'd12);
        chk("loaduse_ctrl0",   64'(bus_if.id_ex_ctrl_out), 64'h0);
        run_cycle(32'h2222_0001, 9'h044);

        // Redirect concurrent with a full stall.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h3333_0000, 9'h155);
        after_edge();
        chk("redir_pc",    64'(bus_if.pc_out),          64'h40);
        chk("redir_instr", 64'(bus_if.if_id_instr_out), 64'h0);
        chk("redir_state", 64'(bus_if.state_out),       64'd2);

        // Watchdog: 15 consecutive stalls (PC held, IF/ID writing).
        for (int i = 0; i < STALL_LIMIT; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, $urandom, 9'h0AA);
        end
        run_cycle(32'h4444_0001, 9'h001);
        run_cycle(32'h4444_0002, 9'h002);
        after_edge();
        chk("timeout_sticky", 64'(bus_if.stall_timeout_out), 64'd1);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5555_0000, 9'h000);
        run_cycle(32'h5555_0001, 9'h003);
        after_edge();
        chk("pc_wrap", 64'(bus_if.pc_out), 64'h0);

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h6666_0000, 9'h0F0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h6666_0001, 9'h0F1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h6666_0002, 9'h0F2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_values("midstall");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus_if.pc_wr_in         = 1'b1;
        bus_if.if_id_wr_in      = 1'b1;
        bus_if.flush_control_in = 1'b0;
        bus_if.branch_taken_in  = 1'b0;

        // First edge after release must be a plain advance.
        run_cycle(32'h7777_0000, 9'h07F);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            pcw = (r[1:0] != 2'd0);
            ifw = (r[3:2] != 2'd0);
            fl  = (r[6:4] == 3'd0);
            br  = (r[11:8] < 4'd2);
            r   = $urandom;
            step(pcw, ifw, fl, br, {r[31:2], 2'b00}, $urandom, r[CTRL_W-1:0]);
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stall_ctl.md
STALL_CTL -- requirements
Module: stall_ctl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CTRL_W, default 9, width of the decoded ID-stage control bundle.
REQ-003 Parameter STALL_LIMIT, default 15, consecutive-stall cycles that trip the watchdog; legal range 1..255.
REQ-004 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n_in  input  1  asynchronous reset, active-low.
REQ-006 pc_wr_in  input  1  PC write enable from the hazard unit; 0 means hold PC.
REQ-007 if_id_wr_in  input  1  IF/ID write enable from the hazard unit; 0 means hold IF/ID.
REQ-008 flush_control_in  input  1  hazard-unit request to bubble ID/EX control.
REQ-009 branch_taken_in  input  1  EX-stage redirect request.
REQ-010 branch_target_in  input  32  redirect PC, valid with branch_taken_in.
REQ-011 instr_in  input  32  instruction memory data for the current pc_out.
REQ-012 ctrl_in  input  CTRL_W  decoded control for the instruction in ID.
REQ-013 pc_out  output  32  current fetch PC.
REQ-014 if_id_pc4_out  output  32  registered PC+4 of the instruction in ID.
REQ-015 if_id_instr_out  output  32  registered instruction in ID.
REQ-016 id_ex_ctrl_out  output  CTRL_W  registered control bundle for EX.
REQ-017 state_out  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-018 stall_timeout_out  output  1  sticky watchdog flag.

Function
REQ-019 Per-cycle priority SHALL be branch_taken_in, then stall (pc_wr_in=0 or if_id_wr_in=0), then normal advance.
REQ-020 Normal: pc_out <= pc_out+4, IF/ID <= {pc_out+4, instr_in}, id_ex_ctrl_out <= ctrl_in, one-cycle latency.
REQ-021 PC addition SHALL be 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 Redirect: pc_out <= branch_target_in, if_id_instr_out <= 32'h0 (NOP), if_id_pc4_out <= 0, id_ex_ctrl_out <= 0, regardless of the hazard inputs.
REQ-023 Stall: PC holds when pc_wr_in=0, and IF/ID holds when if_id_wr_in=0, each independently.
REQ-024 id_ex_ctrl_out SHALL load all-zero whenever flush_control_in=1 and no redirect is active; otherwise it loads ctrl_in.
REQ-025 FSM: RUN->STALL on a stall with no redirect; STALL->RUN when the stall clears; any state->FLUSH on branch_taken_in; FLUSH->RUN next cycle unless the redirect or a stall repeats.
REQ-026 A stall cycle counter SHALL increment on each consecutive stall cycle, saturate at 255, and clear on any non-stall cycle.
REQ-027 stall_timeout_out SHALL set in the cycle the counter reaches STALL_LIMIT and remain 1 until reset.
REQ-028 A redirect concurrent with a stall SHALL clear the stall counter and take the redirect.

Reset
REQ-029 Asserting reset SHALL immediately force pc_out=RESET_PC, IF/ID=0, id_ex_ctrl_out=0, state_out=RUN, counter=0, stall_timeout_out=0, including mid-stall.
REQ-030 The first rising edge after deassertion SHALL perform a normal advance if no hazard input is active.

Configuration
REQ-031 With STALL_STATS_EN defined: add outputs stall_count_out[31:0] (total stall cycles) and flush_count_out[31:0] (total redirects), both reset to 0, wrapping modulo 2^32.
REQ-032 Without STALL_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (RUN, STALL, FLUSH), the NOP constant 32'h0, and PC_STEP=4.
REQ-034 The IF/ID register with hold and flush SHALL be a sub-module named if_id_reg; the FSM, PC, and ID/EX control register remain in stall_ctl.

Verification
REQ-035 Reset PC=0; 3 cycles, no hazards -> pc_out 4, 8, 12; if_id_pc4_out lags by one cycle.
REQ-036 Load-use: pc_wr_in=0, if_id_wr_in=0, flush_control_in=1 for 1 cycle at pc_out=8 -> pc_out holds 8, id_ex_ctrl_out=0, state_out STALL then RUN.
REQ-037 branch_taken_in=1, target 0x40, with a simultaneous stall -> pc_out=0x40, if_id_instr_out=0, state_out=FLUSH, stall counter=0.
REQ-038 Hold a stall for 15 cycles -> stall_timeout_out rises on cycle 15 and remains 1 after the stall clears.
REQ-039 pc_out=0xFFFFFFFC, advance -> pc_out=0x00000000.
REQ-040 Assert reset mid-stall -> all outputs at reset values asynchronously; with STALL_STATS_EN, stall_count_out=0.
